// File: rtl/apu_dmc_dma.sv
// ---------------------------------------------------------------------------
// apu_dmc_dma
// Bus-side responder for the DMC sample fetch. A level request from the DMC
// halts the CPU through RDY, waits out CPU write cycles, lets the CPU's
// halted read repeat once (DUMMY), inserts an ALIGN cycle when needed so
// that the stolen READ lands on a get cycle, then returns the fetched byte
// with a one-CPU-cycle acknowledge. All state advances on cpu_clk_en only.
// ---------------------------------------------------------------------------
module apu_dmc_dma (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        cpu_clk_en,
    input  logic        apu_put,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data,
    output logic        cpu_rdy,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    output logic [15:0] bus_addr,
    input  logic [7:0]  bus_data_in,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_DUMMY = 3'd2,
        ST_ALIGN = 3'd3,
        ST_READ  = 3'd4,
        ST_ACK   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_addr_q;
    logic [7:0]  r_dmc_data;
    logic        w_adv;

    // CPU-cycle advance strobe shared by every register in the block
    assign w_adv = cpu_clk_en;

    // State register: async reset to IDLE, advances only on CPU-cycle strobes
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= ST_IDLE;
        end else if (w_adv) begin
            r_state <= w_state_nxt;
        end else begin
            r_state <= r_state;
        end
    end

    // Next-state logic for the halt / dummy / align / read / ack sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (dmc_req) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HALT: begin
                // A write cycle cannot be halted; wait for the CPU to read
                if (cpu_rw) begin
                    w_state_nxt = ST_DUMMY;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_DUMMY: begin
                // READ must fall on a get cycle: if DUMMY is a put cycle the
                // next one is already a get, otherwise burn one ALIGN cycle
                if (apu_put) begin
                    w_state_nxt = ST_READ;
                end else begin
                    w_state_nxt = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                w_state_nxt = ST_READ;
            end
            ST_READ: begin
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                // Request is ignored here; the DMC drops it on the ack
                w_state_nxt = ST_IDLE;
            end
            default: begin
                // Unreachable encodings recover to IDLE
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sample address latch: captured only when IDLE accepts a request
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_addr_q <= 16'h0000;
        end else if (w_adv && (r_state == ST_IDLE) && dmc_req) begin
            r_addr_q <= dmc_addr;
        end else begin
            r_addr_q <= r_addr_q;
        end
    end

    // Fetched byte: captured at the end of READ, held until the next READ
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_dmc_data <= 8'h00;
        end else if (w_adv && (r_state == ST_READ)) begin
            r_dmc_data <= bus_data_in;
        end else begin
            r_dmc_data <= r_dmc_data;
        end
    end

    // Outputs decoded straight from the state register (glitch-free RDY)
    always_comb begin
        cpu_rdy    = 1'b1;
        dmc_ack    = 1'b0;
        dma_active = 1'b0;
        bus_addr   = cpu_addr;
        case (r_state)
            ST_IDLE: begin
                cpu_rdy = 1'b1;
            end
            ST_HALT, ST_DUMMY, ST_ALIGN: begin
                cpu_rdy = 1'b0;
            end
            ST_READ: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                bus_addr   = r_addr_q;
            end
            ST_ACK: begin
                cpu_rdy = 1'b1;
                dmc_ack = 1'b1;
            end
            default: begin
                cpu_rdy = 1'b1;
            end
        endcase
    end

    assign dmc_data = r_dmc_data;

endmodule

// File: doc/apu_dmc_dma.md
# apu_dmc_dma

Bus-side responder for the DMC sample-fetch request. The DMC memory reader raises a level request with a sample address; this block halts the CPU via RDY, steals the bus for a halt/dummy/(align)/read sequence, and returns the fetched byte with a one-cycle acknowledge. It sits between the APU and the CPU bus mux, clocked with the rest of the APU on `cpu_clk_en`.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst_l` in 1: reset, asynchronous and active-low.
- `cpu_clk_en` in 1: CPU-cycle strobe. All state advances only on `clk` edges where this is 1.
- `apu_put` in 1: 1 during put (odd) CPU cycles, 0 during get cycles. Toggles every CPU cycle.
- `dmc_req` in 1: level request from the DMC (sample buffer empty and bytes remaining).
- `dmc_addr` in 16: sample address for the request.
- `dmc_ack` out 1: high for exactly one CPU cycle when `dmc_data` is valid.
- `dmc_data` out 8: fetched sample byte.
- `cpu_rdy` out 1: 0 halts the CPU.
- `cpu_rw` in 1: 1 when the CPU's current cycle is a read.
- `cpu_addr` in 16: CPU address.
- `bus_addr` out 16: address driven onto the memory bus.
- `bus_data_in` in 8: memory read data.
- `dma_active` out 1: high while the bus is owned by the DMA (READ state).

## Operation
- States: IDLE, HALT, DUMMY, ALIGN, READ, ACK. The state register updates only when `cpu_clk_en`=1.
- IDLE: if `dmc_req`=1, latch `dmc_addr` into `addr_q` and go to HALT. Otherwise stay in IDLE.
- HALT: `cpu_rdy`=0. If `cpu_rw`=1, go to DUMMY, because the CPU stalls on this read. If `cpu_rw`=0, stay in HALT, because write cycles cannot be halted. There is no timeout.
- DUMMY: the CPU repeats its read on its own address. If `apu_put`=1, go to READ. If `apu_put`=0, go to ALIGN. This guarantees READ falls on a get cycle.
- ALIGN: go to READ unconditionally.
- READ:
  - `bus_addr`=`addr_q` and `dma_active`=1.
  - At the end of the cycle, capture `bus_data_in` into `dmc_data`.
  - Go to ACK.
- ACK: `dmc_ack`=1 and `cpu_rdy`=1. Go to IDLE. `dmc_req` is ignored in this cycle; the DMC drops its request on `dmc_ack`.
- `cpu_rdy` = 0 in HALT, DUMMY, ALIGN and READ; 1 in IDLE and ACK. It is decoded directly from the state register, so it is glitch-free.
- `bus_addr` = `addr_q` in READ; `cpu_addr` in all other states.
- `dmc_req` is sampled only in IDLE. Deasserting it after HALT has been entered does not abort the transaction. `dmc_addr` changes after the latch are ignored.
- `dmc_data` holds its value until the next READ.

## Timing
- Reset values: state IDLE, `cpu_rdy`=1, `dmc_ack`=0, `dmc_data`=0x00, `addr_q`=0x0000, `dma_active`=0, `bus_addr`=`cpu_addr`.
- Latency is counted in CPU cycles from the IDLE cycle that samples `dmc_req`=1 to the cycle `dmc_ack` is high. W is the number of CPU write cycles seen in HALT.
  - 4+W when DUMMY has `apu_put`=1.
  - 5+W when DUMMY has `apu_put`=0 (ALIGN inserted).
- CPU stall is 3+W cycles without ALIGN, 4+W with ALIGN.
- `cpu_rdy` is low from the cycle after request sampling through READ inclusive.
- The earliest back-to-back request is sampled in the IDLE cycle following ACK.
- Reset asserted mid-sequence returns the block to IDLE immediately and releases `cpu_rdy` asynchronously. No `dmc_ack` is issued for the aborted fetch.
- When `cpu_clk_en`=0 the block holds all state and outputs.
- Address wrap is the DMC's responsibility; `addr_q` is used verbatim, including 0xFFFF.

## Test plan
- Basic fetch:
  - Stimulus: `dmc_req`=1, `dmc_addr`=0xC040, `cpu_rw`=1, DUMMY on `apu_put`=1, `bus_data_in`=0x5A at READ.
  - Response: `cpu_rdy` low for 3 cycles, `bus_addr`=0xC040 for one cycle, `dmc_ack` for one cycle with `dmc_data`=0x5A.
- Alignment:
  - Stimulus: same as basic fetch, with DUMMY on `apu_put`=0.
  - Response: one ALIGN cycle is inserted, `cpu_rdy` is low for 4 cycles, and READ occurs with `apu_put`=0.
- Write-cycle deferral:
  - Stimulus: `cpu_rw`=0 for 3 cycles after request, then 1.
  - Response: HALT lasts 4 cycles, `bus_addr`=`cpu_addr` throughout, and `dmc_ack` arrives at cycle 7 or 8.
- Request and address changes mid-sequence:
  - Stimulus: deassert `dmc_req` and change `dmc_addr` to 0x1234 during DUMMY.
  - Response: READ still uses the latched address, and `dmc_ack` still pulses.
- Reset mid-sequence:
  - Stimulus: assert `rst_l`=0 during ALIGN.
  - Response: `cpu_rdy`=1 immediately, no `dmc_ack`, `dmc_data`=0x00, and a fresh request after release completes normally.
- Back-to-back and stall:
  - Stimulus: hold `dmc_req`=1 through ACK; separately, hold `cpu_clk_en`=0 for 5 clks during HALT.
  - Response: the second fetch is sampled in the IDLE cycle after ACK; during the `cpu_clk_en` gap, state and outputs are frozen.
